// File: rtl/spi_accel_responder.sv
// SPI mode-3 target standing in for the accelerometer: command byte {R/W, MB, A[5:0]}
// followed by reads or writes into a 64x8 register file with coherent sensor samples at 0x32..0x37.
module spi_accel_responder #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  DEVID       = 8'hE5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sclk,
    input  logic        CS,
    input  logic        sdi,
    output logic        sdo,
    output logic        sdo_oe,
    input  logic        sample_valid,
    input  logic [47:0] sample_data,
    output logic        wr_strobe,
    output logic [5:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, CMD, RD, WR} state_t;

    localparam logic [5:0] SAMPLE_BASE = 6'h32;

    logic [SYNC_STAGES-1:0] sclk_ff, cs_ff, sdi_ff;
    logic       sclk_q, cs_q;
    logic       sclk_s, cs_s, sdi_s;
    logic       sclk_rise, sclk_fall, cs_rise, cs_fall;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] tx_sr;
    logic [6:0] rx_sr;
    logic [7:0] rx_byte;
    logic [5:0] addr, next_addr;
    logic       mb;
    logic       byte_done;
    logic [7:0] mem [64];
    logic       pend_vld;
    logic [47:0] pend_data;

    assign sclk_s    = sclk_ff[SYNC_STAGES-1];
    assign cs_s      = cs_ff[SYNC_STAGES-1];
    assign sdi_s     = sdi_ff[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_q;
    assign sclk_fall = ~sclk_s & sclk_q;
    // cs_q resets low, so a CS fall only counts once CS has been seen high after reset.
    assign cs_rise   = cs_s & ~cs_q;
    assign cs_fall   = ~cs_s & cs_q;
    assign rx_byte   = {rx_sr, sdi_s};
    assign next_addr = mb ? addr + 6'd1 : addr;

    function automatic logic read_only(input logic [5:0] a);
        return (a == 6'h00) || (a >= 6'h32 && a <= 6'h37);
    endfunction

    function automatic logic [7:0] rd_val(input logic [5:0] a);
        return (a == 6'h00) ? DEVID : mem[a];
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_ff <= '1;
            cs_ff   <= '0;
            sdi_ff  <= '0;
            sclk_q  <= 1'b1;
            cs_q    <= 1'b0;
        end else begin
            sclk_ff <= {sclk_ff[SYNC_STAGES-2:0], sclk};
            cs_ff   <= {cs_ff[SYNC_STAGES-2:0], CS};
            sdi_ff  <= {sdi_ff[SYNC_STAGES-2:0], sdi};
            sclk_q  <= sclk_s;
            cs_q    <= cs_s;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= 3'd7;
            tx_sr     <= '0;
            rx_sr     <= '0;
            addr      <= '0;
            mb        <= 1'b0;
            byte_done <= 1'b0;
            sdo       <= 1'b0;
            sdo_oe    <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pend_vld  <= 1'b0;
            pend_data <= '0;
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else begin
            wr_strobe <= 1'b0;
            done      <= 1'b0;

            // Samples arriving mid-transaction wait until busy drops so bursts stay coherent.
            if (busy) begin
                if (sample_valid) begin
                    pend_vld  <= 1'b1;
                    pend_data <= sample_data;
                end
            end else begin
                pend_vld <= 1'b0;
                if (pend_vld)
                    for (int i = 0; i < 6; i++) mem[SAMPLE_BASE + 6'(i)] <= pend_data[8*i +: 8];
                if (sample_valid)
                    for (int i = 0; i < 6; i++) mem[SAMPLE_BASE + 6'(i)] <= sample_data[8*i +: 8];
            end

            if (state != IDLE && cs_rise) begin
                state  <= IDLE;
                busy   <= 1'b0;
                sdo    <= 1'b0;
                sdo_oe <= 1'b0;
                done   <= byte_done;
            end else begin
                case (state)
                    IDLE: begin
                        if (cs_fall) begin
                            state     <= CMD;
                            busy      <= 1'b1;
                            bit_cnt   <= 3'd7;
                            byte_done <= 1'b0;
                        end
                    end
                    default: begin
                        if (sclk_fall && state == RD) begin
                            sdo    <= tx_sr[7];
                            tx_sr  <= {tx_sr[6:0], 1'b0};
                            sdo_oe <= 1'b1;
                        end
                        if (sclk_rise) begin
                            rx_sr   <= rx_byte[6:0];
                            bit_cnt <= bit_cnt - 3'd1;
                            if (bit_cnt == 3'd0) begin
                                byte_done <= 1'b1;
                                if (state == CMD) begin
                                    addr <= rx_byte[5:0];
                                    mb   <= rx_byte[6];
                                    if (rx_byte[7]) begin
                                        state <= RD;
                                        tx_sr <= rd_val(rx_byte[5:0]);
                                    end else begin
                                        state <= WR;
                                    end
                                end else begin
                                    addr <= next_addr;
                                    if (state == RD) begin
                                        tx_sr <= rd_val(next_addr);
                                    end else if (!read_only(addr)) begin
                                        mem[addr] <= rx_byte;
                                        wr_strobe <= 1'b1;
                                        wr_addr   <= addr;
                                        wr_data   <= rx_byte;
                                    end
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_accel_responder.sv
// Bench for spi_accel_responder: a bit-banged mode-3 master plus a register-file model
// that predicts read data, accepted writes and deferred sample loads.
module tb_spi_accel_responder;
    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk = 1'b1;
    logic        CS = 1'b1;
    logic        sdi = 1'b0;
    logic        sample_valid = 1'b0;
    logic [47:0] sample_data = '0;
    logic        sdo, sdo_oe, wr_strobe, busy, done;
    logic [5:0]  wr_addr;
    logic [7:0]  wr_data;

    spi_accel_responder #(.SYNC_STAGES(2), .DEVID(8'hE5)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .CS(CS), .sdi(sdi),
        .sdo(sdo), .sdo_oe(sdo_oe), .sample_valid(sample_valid), .sample_data(sample_data),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int wr_cnt = 0;

    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (wr_strobe) wr_cnt <= wr_cnt + 1;
    end

    // Register-file model
    logic [7:0]  m_mem [64];
    logic [47:0] m_pend;
    bit          m_pend_vld = 0;
    int          exp_wr = 0;
    logic [5:0]  exp_wa = '0;
    logic [7:0]  exp_wd = '0;

    function automatic logic [7:0] m_rd(input logic [5:0] a);
        return (a == 6'h00) ? 8'hE5 : m_mem[a];
    endfunction

    function automatic bit m_ro(input logic [5:0] a);
        return (a == 6'h00) || (a >= 6'h32 && a <= 6'h37);
    endfunction

    task automatic m_sample(input logic [47:0] d);
        for (int i = 0; i < 6; i++) m_mem[50 + i] = d[8*i +: 8];
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx,
                            output bit oe_all, output bit oe_any);
        rx = '0; oe_all = 1; oe_any = 0;
        for (int i = 7; i > 7 - n; i--) begin
            sclk = 1'b0;
            sdi  = tx[i];
            tick(HALF);
            rx[i]  = sdo;
            oe_all = oe_all & sdo_oe;
            oe_any = oe_any | sdo_oe;
            sclk = 1'b1;
            tick(HALF);
        end
    endtask

    task automatic pulse_sample(input logic [47:0] d);
        sample_data  = d;
        sample_valid = 1'b1;
        tick(1);
        sample_valid = 1'b0;
    endtask

    task automatic idle_sample(input logic [47:0] d);
        pulse_sample(d);
        m_sample(d);
        tick(1);
    endtask

    // One full transaction; samp_after >= 0 injects a sample after that data byte.
    task automatic txn(input bit rw, input bit mb, input logic [5:0] a, input int nb,
                       input logic [63:0] wd, input int tail_bits,
                       input int samp_after, input logic [47:0] samp);
        logic [7:0] rx, ex;
        logic [5:0] cur;
        bit oa, on;
        int d0;
        d0 = done_cnt;
        CS = 1'b0;
        tick(HALF);
        check("busy_in_txn", 64'(busy), 64'(1));
        spi_bits({rw, mb, a}, 8, rx, oa, on);
        check("oe_during_cmd", 64'(on), 64'(0));
        cur = a;
        for (int k = 0; k < nb; k++) begin
            if (rw) begin
                ex = m_rd(cur);
                spi_bits(8'($urandom), 8, rx, oa, on);
                check($sformatf("rd_%0h", cur), 64'(rx), 64'(ex));
                check("oe_rd_byte", 64'(oa), 64'(1));
            end else begin
                spi_bits(wd[8*k +: 8], 8, rx, oa, on);
                check("oe_wr_byte", 64'(on), 64'(0));
                if (!m_ro(cur)) begin
                    m_mem[cur] = wd[8*k +: 8];
                    exp_wr++;
                    exp_wa = cur;
                    exp_wd = wd[8*k +: 8];
                end
            end
            if (mb) cur = cur + 6'd1;
            if (k == samp_after) begin
                pulse_sample(samp);
                m_pend = samp;
                m_pend_vld = 1;
            end
        end
        if (tail_bits > 0) spi_bits(8'($urandom), tail_bits, rx, oa, on);
        CS = 1'b1;
        tick(HALF);
        check("done_pulse", 64'(done_cnt - d0), 64'(1));
        check("busy_end", 64'(busy), 64'(0));
        check("oe_end", 64'({sdo_oe, sdo}), 64'(0));
        check("wr_count", 64'(wr_cnt), 64'(exp_wr));
        if (exp_wr > 0) check("wr_last", 64'({wr_addr, wr_data}), 64'({exp_wa, exp_wd}));
        if (m_pend_vld) begin
            m_sample(m_pend);
            m_pend_vld = 0;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] rx;
        bit oa, on;
        int d0;
        for (int i = 0; i < 64; i++) m_mem[i] = '0;
        tick(3);
        check("rst_outs", 64'({sdo, sdo_oe, wr_strobe, busy, done}), 64'(0));
        check("rst_wr", 64'({wr_addr, wr_data}), 64'(0));
        rst_n = 1'b1;
        tick(HALF);

        // Device ID, single byte
        txn(1, 0, 6'h00, 1, '0, 0, -1, '0);
        // Write then read back
        txn(0, 0, 6'h2D, 1, 64'h08, 0, -1, '0);
        check("wr_2d", 64'({wr_addr, wr_data}), 64'({6'h2D, 8'h08}));
        txn(1, 0, 6'h2D, 1, '0, 0, -1, '0);
        // Coherent burst with a sample arriving mid-read
        idle_sample(48'h0605_0403_0201);
        txn(1, 1, 6'h32, 6, '0, 0, 1, 48'hAAAA_AAAA_AAAA);
        txn(1, 1, 6'h32, 6, '0, 0, -1, '0);
        // Write burst wrapping 0x3F -> 0x00 (read-only), then an aborted partial byte
        txn(0, 1, 6'h3F, 2, 64'h2211, 4, -1, '0);
        txn(1, 1, 6'h3F, 3, '0, 0, -1, '0);

        // Randomised traffic
        for (int n = 0; n < 14; n++) begin
            if ($urandom_range(2) == 0) idle_sample({$urandom, 16'($urandom)});
            txn(1'($urandom), 1'($urandom), 6'($urandom), int'($urandom_range(3, 1)),
                {$urandom, $urandom}, (n % 3 == 0) ? int'($urandom_range(7, 1)) : 0,
                (n % 4 == 1) ? 0 : -1, {$urandom, 16'($urandom)});
        end

        // Reset mid-read discards state, registers and a pending sample
        CS = 1'b0;
        tick(HALF);
        spi_bits(8'hF2, 8, rx, oa, on);
        pulse_sample(48'h1234_5678_9ABC);
        spi_bits(8'h00, 3, rx, oa, on);
        sclk = 1'b0;
        tick(HALF);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("rst_mid", 64'({sdo, sdo_oe, busy}), 64'(0));
        for (int i = 0; i < 64; i++) m_mem[i] = '0;
        m_pend_vld = 0;
        exp_wr = 0;
        wr_cnt = 0;
        d0 = done_cnt;
        sclk = 1'b1;
        tick(HALF);
        CS = 1'b1;
        tick(2 * HALF);
        check("no_done_after_rst", 64'(done_cnt - d0), 64'(0));
        check("wr_regs_after_rst", 64'({wr_addr, wr_data}), 64'(0));
        txn(1, 1, 6'h32, 6, '0, 0, -1, '0);
        txn(1, 0, 6'h00, 1, '0, 0, -1, '0);
        txn(1, 0, 6'h2D, 1, '0, 0, -1, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
